// File: rtl/gray_pkg.sv
// ----------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for 4-bit Gray-code handling.
//   nibble_t   : 4-bit Gray or binary value
//   gray2bin   : Gray -> natural binary (MSB passes through, each lower bit is
//                the XOR of itself with every more significant Gray bit)
//   popcount4  : number of set bits in a nibble (0..4)
// ----------------------------------------------------------------------------
package gray_pkg;

    typedef logic [3:0] nibble_t;

    // Running XOR from the MSB down: b[i] = g[3] ^ g[2] ^ ... ^ g[i].
    function automatic nibble_t gray2bin(input nibble_t g);
        nibble_t b;
        logic    acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic logic [2:0] popcount4(input nibble_t v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// ----------------------------------------------------------------------------
// gray_to_binary
// 4-bit Gray-code to natural-binary decoder with a registered copy of the
// result and an optional Gray-adjacency checker.
//
// Parameters
//   CHECK_EN  1 = adjacency checker active, 0 = step_err tied low
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   s3..s0     in   Gray input, s3 is MSB
//   vld        in   sample strobe for the clocked path
//   clr_err    in   synchronous clear of step_err
//   b3..b0     out  combinational binary decode, b3 is MSB
//   b_q        out  registered {b3,b2,b1,b0}, captured on vld
//   vld_q      out  b_q valid, one cycle after vld
//   step_err   out  sticky flag: two consecutive valid samples differed in
//                   more than one bit
// ----------------------------------------------------------------------------
module gray_to_binary
    import gray_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s3,
    input  logic       s2,
    input  logic       s1,
    input  logic       s0,
    input  logic       vld,
    input  logic       clr_err,
    output logic       b3,
    output logic       b2,
    output logic       b1,
    output logic       b0,
    output logic [3:0] b_q,
    output logic       vld_q,
    output logic       step_err
);

    nibble_t gray;
    nibble_t bin;

    // Decode path: pure combinational, no dependence on clk or rst.
    assign gray          = {s3, s2, s1, s0};
    assign bin           = gray2bin(gray);
    assign {b3, b2, b1, b0} = bin;

    // Clocked path: registered result plus the history needed by the checker.
    nibble_t b_q_reg;
    logic    vld_q_reg;
    nibble_t prev_gray_reg;
    logic    prev_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q_reg        <= '0;
            vld_q_reg      <= 1'b0;
            prev_gray_reg  <= '0;
            prev_valid_reg <= 1'b0;
        end else begin
            vld_q_reg <= vld;
            if (vld) begin
                b_q_reg        <= bin;
                prev_gray_reg  <= gray;
                prev_valid_reg <= 1'b1;
            end
        end
    end

    assign b_q   = b_q_reg;
    assign vld_q = vld_q_reg;

    generate
        if (CHECK_EN) begin : g_check
            logic step_err_reg;
            logic jump;

            // Only compare against a sample taken since the last reset; the
            // first sample has no predecessor and is always accepted.
            assign jump = vld && prev_valid_reg &&
                          (popcount4(prev_gray_reg ^ gray) >= 3'd2);

            // A new error takes priority over a simultaneous clear so that
            // an illegal jump is never lost.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    step_err_reg <= 1'b0;
                end else if (jump) begin
                    step_err_reg <= 1'b1;
                end else if (clr_err) begin
                    step_err_reg <= 1'b0;
                end
            end

            assign step_err = step_err_reg;
        end else begin : g_no_check
            logic unused_check_inputs;
            assign unused_check_inputs = ^{clr_err, prev_gray_reg, prev_valid_reg};
            assign step_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_gray_to_binary.sv
// ----------------------------------------------------------------------------
// tb_gray_to_binary
// Scoreboard bench: the driver computes the expected registered result and
// error flag from a behavioural model and queues it; a monitor pops and
// compares whenever vld_q is presented.
// ----------------------------------------------------------------------------
module tb_gray_to_binary;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] g_in = 4'h0;
    logic       vld = 1'b0;
    logic       clr_err = 1'b0;
    logic       b3, b2, b1, b0;
    logic [3:0] b_q;
    logic       vld_q;
    logic       step_err;

    gray_to_binary #(.CHECK_EN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .s3       (g_in[3]),
        .s2       (g_in[2]),
        .s1       (g_in[1]),
        .s0       (g_in[0]),
        .vld      (vld),
        .clr_err  (clr_err),
        .b3       (b3),
        .b2       (b2),
        .b1       (b1),
        .b0       (b0),
        .b_q      (b_q),
        .vld_q    (vld_q),
        .step_err (step_err)
    );

    always #5 if (clk_en) clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] bin;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [3:0] m_prev = 4'h0;
    logic       m_pv   = 1'b0;
    logic       m_err  = 1'b0;
    logic [3:0] cur_g  = 4'h0;

    // Reference: the binary value n is the one whose Gray code n^(n>>1)
    // equals the observed pattern.
    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        logic [3:0] r;
        r = 4'h0;
        for (int n = 0; n < 16; n++) begin
            if (4'(n ^ (n >> 1)) == g) r = 4'(n);
        end
        return r;
    endfunction

    function automatic int bits_differing(input logic [3:0] a, input logic [3:0] b);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] != b[i]) c++;
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus, applied just after a rising edge; the model
    // predicts the state visible after the following rising edge.
    task automatic drive(input logic v, input logic [3:0] g, input logic c);
        logic jump;
        @(posedge clk);
        #1;
        g_in    = g;
        vld     = v;
        clr_err = c;
        if (v) begin
            jump = m_pv && (bits_differing(m_prev, g) >= 2);
            if (jump)   m_err = 1'b1;
            else if (c) m_err = 1'b0;
            exp_q.push_back('{bin: ref_bin(g), err: m_err});
            m_prev = g;
            m_pv   = 1'b1;
            $display("[TB] sample gray=%b expect b_q=%b step_err=%b", g, ref_bin(g), m_err);
        end else if (c) begin
            m_err = 1'b0;
        end
    endtask

    // Reset pulse between clock edges; outputs must clear without an edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst     = 1'b1;
        vld     = 1'b0;
        clr_err = 1'b0;
        m_pv    = 1'b0;
        m_err   = 1'b0;
        exp_q.delete();
        #1;
        check("rst_b_q", {4'h0, b_q}, 8'h00);
        check("rst_vld_q", {7'h0, vld_q}, 8'h00);
        check("rst_step_err", {7'h0, step_err}, 8'h00);
        #3;
        rst = 1'b0;
    endtask

    // Monitor: combinational decode every cycle, registered path on vld_q.
    always @(negedge clk) begin
        if (!rst) begin
            check("comb_decode", {4'h0, b3, b2, b1, b0}, {4'h0, ref_bin(g_in)});
            if (vld_q) begin
                if (exp_q.size() == 0) begin
                    check("vld_q_spurious", {7'h0, vld_q}, 8'h00);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("b_q", {4'h0, b_q}, {4'h0, mon_e.bin});
                    check("step_err", {7'h0, step_err}, {7'h0, mon_e.err});
                    $display("[TB] out b_q=%b step_err=%b", b_q, step_err);
                end
            end
        end
    end

    initial begin
        // Clockless sweep with reset held: decode must still follow inputs.
        #1;
        check("init_b_q", {4'h0, b_q}, 8'h00);
        check("init_vld_q", {7'h0, vld_q}, 8'h00);
        check("init_step_err", {7'h0, step_err}, 8'h00);
        for (int n = 0; n < 16; n++) begin
            g_in = 4'(n ^ (n >> 1));
            #10;
            check("sweep", {4'h0, b3, b2, b1, b0}, 8'(n));
            $display("[TB] sweep gray=%b b=%b", g_in, {b3, b2, b1, b0});
        end

        g_in   = 4'h0;
        rst    = 1'b0;
        clk_en = 1'b1;

        // Adjacent steps: 0000, 0001, 0011.
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b1, 4'b0001, 1'b0);
        drive(1'b1, 4'b0011, 1'b0);
        drive(1'b0, 4'b0011, 1'b0);

        // Two-bit jump, clear, then jump coinciding with clear.
        do_reset();
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b1, 4'b0110, 1'b0);
        drive(1'b0, 4'b0110, 1'b1);
        drive(1'b0, 4'b0110, 1'b0);
        check("clr_err", {7'h0, step_err}, 8'h00);
        drive(1'b1, 4'b0000, 1'b1);
        drive(1'b1, 4'b0001, 1'b0);

        // Mid-stream reset with vld_q, b_q and step_err all set.
        do_reset();

        // Wrap-around 1000 -> 0000 is a single-bit change.
        drive(1'b1, 4'b1000, 1'b0);
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);

        // Reset discards history: 0000 | reset | 1111 is not an error.
        do_reset();
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        do_reset();
        drive(1'b1, 4'b1111, 1'b0);
        drive(1'b0, 4'b1111, 1'b0);

        // Randomized stream: mostly legal steps, occasional jumps and clears.
        cur_g = 4'h0;
        for (int i = 0; i < 300; i++) begin
            logic       v;
            logic       c;
            logic [3:0] g;
            if (i % 100 == 50) do_reset();
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) < 8) begin
                g = cur_g;
                if ($urandom_range(0, 4) != 0) g[$urandom_range(0, 3)] = ~g[$urandom_range(0, 3)];
            end else begin
                g = 4'($urandom_range(0, 15));
            end
            if (v) cur_g = g;
            drive(v, g, c);
        end
        drive(1'b0, cur_g, 1'b0);

        // Bounded drain of outstanding expectations.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("queue_drain", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
